// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word per line.
// Load hits complete in the request cycle; misses and stores stall while the backing memory responds.
module data_cache #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int SETS          = 16,
  parameter int INDEX_BITS    = $clog2(SETS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  input  logic                     flush,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     stall,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
);

  localparam int TAG_BITS = ADDRESS_WIDTH - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t                state;
  logic [SETS-1:0]       valid;
  logic [TAG_BITS-1:0]   tag_array  [SETS];
  logic [DATA_WIDTH-1:0] data_array [SETS];
  logic                  just_filled;

  logic [INDEX_BITS-1:0] index;
  logic [INDEX_BITS-1:0] mem_index;
  logic [TAG_BITS-1:0]   tag;
  logic [TAG_BITS-1:0]   mem_tag;
  logic                  hit;
  logic                  mem_hit;
  logic                  addr_unused;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign index       = req_addr[INDEX_BITS+1:2];
  assign tag         = req_addr[ADDRESS_WIDTH-1:INDEX_BITS+2];
  assign hit         = valid[index] && (tag_array[index] == tag);
  assign addr_unused = ^req_addr[1:0];

  // The outstanding transaction is tracked only through the captured memory address.
  assign mem_index = mem_addr[INDEX_BITS+1:2];
  assign mem_tag   = mem_addr[ADDRESS_WIDTH-1:INDEX_BITS+2];
  assign mem_hit   = valid[mem_index] && (tag_array[mem_index] == mem_tag);

  assign rdata = hit ? data_array[index] : '0;

  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = req_valid && (req_we || !hit);
      FILL:    stall = 1'b1;
      WRITE:   stall = !mem_ack;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      valid       <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
      just_filled <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          just_filled <= 1'b0;
          if (flush) valid <= '0;
          if (req_valid) begin
            if (req_we) begin
              state     <= WRITE;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= {req_addr[ADDRESS_WIDTH-1:2], 2'b00};
              mem_wdata <= req_wdata;
            end else if (hit) begin
              // The retiring cycle of a filled miss was already counted as a miss.
              if (!just_filled) hit_count <= sat_inc(hit_count);
            end else begin
              state      <= FILL;
              mem_req    <= 1'b1;
              mem_we     <= 1'b0;
              mem_addr   <= {req_addr[ADDRESS_WIDTH-1:2], 2'b00};
              miss_count <= sat_inc(miss_count);
            end
          end
        end
        FILL: begin
          if (mem_ack) begin
            valid[mem_index] <= 1'b1;
            state            <= IDLE;
            mem_req          <= 1'b0;
            just_filled      <= 1'b1;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data storage carries no reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (state == FILL && mem_ack) begin
      tag_array[mem_index]  <= mem_tag;
      data_array[mem_index] <= mem_rdata;
    end else if (state == WRITE && mem_ack && mem_hit) begin
      data_array[mem_index] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: loads, stores, eviction, flush and mid-fill reset,
// with a memory responder that acknowledges after a chosen number of request cycles.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        flush = 1'b0;
  logic [31:0] rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int errors = 0;
  int checks = 0;

  int          stalls;
  logic [31:0] rd;
  logic        saw_req;
  logic        saw_we;
  logic [31:0] saw_addr;
  logic [31:0] saw_wdata;

  data_cache dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .rdata(rdata), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one CPU access starting just after a rising edge; hold it until stall drops.
  // The memory acks on the lat-th cycle in which mem_req is seen high.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input int lat, input logic [31:0] mrd);
    int  n;
    bit  done;
    n = 0; done = 0; stalls = 0; rd = '0;
    saw_req = 0; saw_we = 0; saw_addr = '0; saw_wdata = '0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (mem_req) begin
        n++;
        saw_req = 1; saw_we = mem_we; saw_addr = mem_addr; saw_wdata = mem_wdata;
        mem_ack = (n == lat);
        mem_rdata = mrd;
      end
      #1;
      if (!stall) begin
        rd = rdata;
        done = 1;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    req_valid = 1'b0; req_we = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL access_timeout: addr %h still stalled after 50 cycles", addr);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_hits", hit_count, 32'd0);
    check("rst_misses", miss_count, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Cold load miss, 3-cycle memory
    access(1'b0, 32'h0000_0040, 32'h0, 3, 32'hDEAD_BEEF);
    check("miss_stalls", stalls, 32'd4);
    check("miss_rdata", rd, 32'hDEAD_BEEF);
    check("miss_mem_addr", saw_addr, 32'h0000_0040);
    check("miss_mem_we", {31'd0, saw_we}, 32'd0);
    check("miss_misses", miss_count, 32'd1);
    check("miss_hits", hit_count, 32'd0);

    // Repeat load hits with no memory traffic
    access(1'b0, 32'h0000_0040, 32'h0, 1, 32'h0);
    check("hit_stalls", stalls, 32'd0);
    check("hit_req", {31'd0, saw_req}, 32'd0);
    check("hit_rdata", rd, 32'hDEAD_BEEF);
    check("hit_hits", hit_count, 32'd1);

    // Store hit, ack after 2 cycles
    access(1'b1, 32'h0000_0040, 32'h1234_5678, 2, 32'h0);
    check("st_stalls", stalls, 32'd2);
    check("st_mem_we", {31'd0, saw_we}, 32'd1);
    check("st_mem_addr", saw_addr, 32'h0000_0040);
    check("st_mem_wdata", saw_wdata, 32'h1234_5678);
    check("st_misses", miss_count, 32'd1);
    access(1'b0, 32'h0000_0040, 32'h0, 1, 32'h0);
    check("st_hit_stalls", stalls, 32'd0);
    check("st_hit_rdata", rd, 32'h1234_5678);
    check("st_hit_hits", hit_count, 32'd2);

    // Store miss does not allocate
    access(1'b1, 32'h0000_0080, 32'hCAFE_F00D, 1, 32'h0);
    check("stm_stalls", stalls, 32'd1);
    check("stm_mem_addr", saw_addr, 32'h0000_0080);
    access(1'b0, 32'h0000_0080, 32'h0, 2, 32'hCAFE_F00D);
    check("stm_ld_req", {31'd0, saw_req}, 32'd1);
    check("stm_ld_stalls", stalls, 32'd3);
    check("stm_ld_rdata", rd, 32'hCAFE_F00D);
    check("stm_ld_misses", miss_count, 32'd2);

    // Aliasing on index 0: 0x40, 0x440, 0x40 each miss
    access(1'b0, 32'h0000_0040, 32'h0, 1, 32'h1234_5678);
    check("alias1_stalls", stalls, 32'd2);
    access(1'b0, 32'h0000_0440, 32'h0, 1, 32'h4444_4444);
    check("alias2_stalls", stalls, 32'd2);
    check("alias2_rdata", rd, 32'h4444_4444);
    access(1'b0, 32'h0000_0040, 32'h0, 1, 32'h1234_5678);
    check("alias3_stalls", stalls, 32'd2);
    check("alias_misses", miss_count, 32'd5);
    check("alias_hits", hit_count, 32'd2);

    // Byte offset bits are ignored
    access(1'b0, 32'h0000_0042, 32'h0, 1, 32'h0);
    check("offs_stalls", stalls, 32'd0);
    check("offs_rdata", rd, 32'h1234_5678);
    check("offs_hits", hit_count, 32'd3);

    // Warm a second line, then flush
    access(1'b0, 32'h0000_0044, 32'h0, 1, 32'h5555_5555);
    access(1'b0, 32'h0000_0044, 32'h0, 1, 32'h0);
    check("warm_stalls", stalls, 32'd0);
    check("warm_hits", hit_count, 32'd4);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    access(1'b0, 32'h0000_0040, 32'h0, 1, 32'h1234_5678);
    check("flush40_stalls", stalls, 32'd2);
    access(1'b0, 32'h0000_0044, 32'h0, 1, 32'h5555_5555);
    check("flush44_stalls", stalls, 32'd2);
    check("flush_misses", miss_count, 32'd8);

    // Reset in the middle of a fill
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0080;
    @(negedge clk);
    check("mid_idle_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_fill_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_hits", hit_count, 32'd0);
    check("mid_rst_misses", miss_count, 32'd0);
    check("mid_rst_addr", mem_addr, 32'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    check("late_ack_req", {31'd0, mem_req}, 32'd0);
    check("late_ack_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_req2", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    access(1'b0, 32'h0000_0080, 32'h0, 1, 32'h7777_7777);
    check("post_rst_stalls", stalls, 32'd2);
    check("post_rst_rdata", rd, 32'h7777_7777);
    check("post_rst_misses", miss_count, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the memory pipeline stage and the backing data memory.
- Serves CPU loads and stores with a single-cycle hit path and stalls the pipeline on misses and writes.
- Backing memory is reached through a req/ack handshake with variable latency.

Parameters:
DATA_WIDTH, 32, word width of CPU and memory data
ADDRESS_WIDTH, 32, byte address width
SETS, 16, number of cache lines (power of two, >=2); one word per line
INDEX_BITS, $clog2(SETS), index field width (derived)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
req_valid  in  1  CPU access request this cycle
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDRESS_WIDTH  byte address; bits [1:0] ignored
req_wdata  in  DATA_WIDTH  store data
flush  in  1  invalidate all lines
rdata  out  DATA_WIDTH  load data; valid when req_valid & !req_we & !stall
stall  out  1  hold pipeline (drives stallf/stalld upstream)
mem_req  out  1  backing-memory request
mem_we  out  1  backing-memory write enable
mem_addr  out  ADDRESS_WIDTH  word-aligned address, bits [1:0]=0
mem_wdata  out  DATA_WIDTH  backing-memory write data
mem_ack  in  1  backing memory completes request this cycle
mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack
hit_count  out  32  saturating load-hit counter
miss_count  out  32  saturating load-miss counter

Behaviour:
- Address split:
  - index = req_addr[INDEX_BITS+1:2]
  - tag = req_addr[ADDRESS_WIDTH-1:INDEX_BITS+2]
  - hit = valid[index] & (tag_array[index] == tag)
- Storage per line: valid bit, tag, data word. Arrays are sequentially written, combinationally read.
- Reset (rst low, asynchronous):
  - all valid bits cleared; state = IDLE
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
  - hit_count=0, miss_count=0
  - rdata is 0 when no hit is presented
- Reset asserted mid-miss or mid-write abandons the transaction. A later mem_ack in IDLE is ignored.
- FSM states: IDLE, FILL, WRITE.
- IDLE:
  - !req_valid: stall=0, mem_req=0.
  - Load hit: stall=0, rdata=line data (zero latency), hit_count+1; stay in IDLE.
  - Load miss: stall=1 combinationally; capture word-aligned addr into mem_addr; miss_count+1; go to FILL.
  - Store (hit or miss): stall=1; capture mem_addr and mem_wdata=req_wdata; go to WRITE.
- FILL:
  - mem_req=1, mem_we=0, stall=1.
  - On mem_ack: write mem_rdata, tag and valid=1 into the line; go to IDLE. stall stays 1 in the ack cycle.
  - The held request hits on the next cycle, so load-miss latency = memory latency + 1 cycles of stall.
- WRITE:
  - mem_req=1, mem_we=1, stall=1 while mem_ack=0.
  - In the ack cycle: stall=0 (store retires).
  - If the captured address hits, the line data is updated with mem_wdata in that same edge. A store miss allocates nothing.
  - Go to IDLE.
- mem_req, mem_we, mem_addr and mem_wdata are held constant from FILL/WRITE entry until the ack cycle inclusive. The CPU holds its request while stall=1, but the cache uses only captured values.
- mem_req drops in the cycle after ack. No back-to-back request without passing through IDLE.
- flush:
  - Sampled only in IDLE. Clears all valid bits at the clock edge.
  - A request in the same cycle is evaluated against pre-flush state; its fill/write proceeds normally.
  - flush asserted in FILL/WRITE is ignored; the requester holds it until stall=0.
- Counters:
  - hit_count and miss_count saturate at 32'hFFFF_FFFF.
  - Stores are not counted.
  - The post-fill hit cycle does not increment hit_count; the access is counted once, as a miss.
- Aliasing: two addresses with the same index and different tags evict each other on fill.

Test Plan:
- Reset, then load 0x0000_0040 with memory returning 0xDEADBEEF after 3 cycles: stall=1 for 4 cycles, then rdata=0xDEADBEEF with stall=0; miss_count=1, hit_count=0.
- Repeat load 0x0000_0040: stall=0 same cycle, rdata=0xDEADBEEF, no mem_req; hit_count=1.
- Store 0x12345678 to 0x40 (hit), ack after 2 cycles: mem_we=1, mem_addr=0x40, stall deasserts in the ack cycle. A following load of 0x40 hits with 0x12345678.
- Store to 0x80 (miss), then load 0x80: store does not allocate; the load misses and issues a FILL; miss_count increments.
- Load 0x40, then load 0x440 (same index, SETS=16), then 0x40 again: each access misses (eviction).
- Assert flush in IDLE after warm lines, then load 0x40: the load misses. Separately, assert rst low mid-FILL: mem_req=0 immediately; a later mem_ack is ignored; counters read 0.
